// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock frequency monitor.
//   mon_state_e     : measurement FSM states
//   DAC_CLK_PER_PS  : reference (dac_clk) period in picoseconds
//   calc_exp_edges  : expected toggle transitions per window for a given
//                     monitored-clock period and toggle divider
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_MEASURE   = 2'd2
  } mon_state_e;

  localparam int unsigned DAC_CLK_PER_PS = 3125;

  // Transitions per window = window * f_mon / (f_ref * div), rounded to nearest.
  function automatic int unsigned calc_exp_edges(input int unsigned window,
                                                 input int unsigned mon_per_ps,
                                                 input int unsigned toggle_div);
    longint unsigned num;
    longint unsigned den;
    den = 64'(mon_per_ps) * 64'(toggle_div);
    if (den == 64'd0) begin
      return 32'd0;
    end
    num = 64'(window) * 64'(DAC_CLK_PER_PS);
    return 32'((num + (den >> 1)) / den);
  endfunction

endpackage

// File: rtl/clk_mon_sync.sv
// Two-flop synchronizer for asynchronous single-bit or multi-bit level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (flops clear to 0)
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module clk_mon_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // Next values of the synchronizer chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Frequency and lock checker for a clocking-wizard output, running on dac_clk.
// Counts transitions of a toggle generated in the monitored domain over a fixed
// window of dac_clk cycles and compares the count against EXP_EDGES +/- TOL.
//   dac_clk    : reference clock (sole clock)
//   reset_n    : asynchronous active-low reset
//   locked     : MMCM locked, asynchronous
//   mon_toggle : toggle from the monitored domain, asynchronous
//   clear_err  : single-cycle pulse clearing freq_err
//   meas_valid : one-cycle pulse when meas_count updates
//   meas_count : transitions counted in the last completed window (saturating)
//   freq_ok    : last window within tolerance while locked
//   freq_err   : sticky, some completed window was out of tolerance
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WINDOW    = 1024,
  parameter int unsigned SETTLE    = 64,
  parameter int unsigned EXP_EDGES = 512,
  parameter int unsigned TOL       = 2
) (
  input  logic             dac_clk,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             mon_toggle,
  input  logic             clear_err,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             freq_ok,
  output logic             freq_err
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned DIF_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE - 1);
  localparam logic [DIF_W-1:0] EXP_DIF    = DIF_W'(EXP_EDGES);
  localparam logic [DIF_W-1:0] TOL_DIF    = DIF_W'(TOL);

  mon_state_e state_q, state_d;

  logic             locked_s;
  logic             mon_s;
  logic             hist_q, hist_d;
  logic             edge_c;

  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] edge_inc_c;

  logic signed [DIF_W-1:0] diff_c;
  logic        [DIF_W-1:0] abs_c;
  logic                    in_tol_c;
  logic                    err_set_c;

  logic             meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0] meas_count_q, meas_count_d;
  logic             freq_ok_q, freq_ok_d;
  logic             freq_err_q, freq_err_d;

  clk_mon_sync #(.W(1)) u_sync_locked (
    .clk   (dac_clk),
    .rst_n (reset_n),
    .d     (locked),
    .q     (locked_s)
  );

  clk_mon_sync #(.W(1)) u_sync_toggle (
    .clk   (dac_clk),
    .rst_n (reset_n),
    .d     (mon_toggle),
    .q     (mon_s)
  );

  // Edge detect on the synchronized toggle; any change is one transition.
  always_comb begin
    hist_d = mon_s;
    edge_c = mon_s ^ hist_q;
  end

  // Saturating edge count including this cycle's edge, and its tolerance check.
  always_comb begin
    edge_inc_c = edge_cnt_q;
    if (edge_c && (edge_cnt_q != CNT_MAX)) begin
      edge_inc_c = edge_cnt_q + CNT_W'(1);
    end
    diff_c   = $signed({1'b0, edge_inc_c}) - $signed(EXP_DIF);
    abs_c    = diff_c[DIF_W-1] ? $unsigned(-diff_c) : $unsigned(diff_c);
    in_tol_c = (abs_c <= TOL_DIF);
  end

  // FSM state register.
  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; loss of lock overrides everything.
  always_comb begin
    state_d = state_q;
    if (!locked_s) begin
      state_d = ST_WAIT_LOCK;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: state_d = ST_SETTLE;
        ST_SETTLE:    if (settle_cnt_q == SET_LAST) state_d = ST_MEASURE;
        ST_MEASURE:   state_d = ST_MEASURE;
        default:      state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  // Counters and measurement outputs. Counters default to 0, so leaving a
  // state (including on lock loss) discards any partial window.
  always_comb begin
    settle_cnt_d = '0;
    win_cnt_d    = '0;
    edge_cnt_d   = '0;
    meas_valid_d = 1'b0;
    meas_count_d = meas_count_q;
    freq_ok_d    = freq_ok_q;
    err_set_c    = 1'b0;
    if (!locked_s) begin
      freq_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_cnt_q != SET_LAST) begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end
        ST_MEASURE: begin
          if (win_cnt_q == WIN_LAST) begin
            // An edge on the closing cycle belongs to the closing window.
            meas_count_d = edge_inc_c;
            meas_valid_d = 1'b1;
            freq_ok_d    = in_tol_c;
            err_set_c    = ~in_tol_c;
          end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            edge_cnt_d = edge_inc_c;
          end
        end
        default: ;
      endcase
    end
    // A new error wins over a simultaneous clear.
    if (err_set_c) begin
      freq_err_d = 1'b1;
    end else if (clear_err) begin
      freq_err_d = 1'b0;
    end else begin
      freq_err_d = freq_err_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q       <= 1'b0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      meas_count_q <= '0;
      freq_ok_q    <= 1'b0;
      freq_err_q   <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      meas_valid_q <= meas_valid_d;
      meas_count_q <= meas_count_d;
      freq_ok_q    <= freq_ok_d;
      freq_err_q   <= freq_err_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign meas_count = meas_count_q;
  assign freq_ok    = freq_ok_q;
  assign freq_err   = freq_err_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: a 16-bit instance with default parameters and an
// 8-bit instance (EXP_EDGES 250) sharing the same stimulus. Expected counts
// come from the recorded toggle history: a window reported at posedge V
// covers toggle-sample transitions rec[j] -> rec[j+1] for j = V-1026 .. V-3.
module tb_clk_freq_monitor;

  localparam int RECN    = 65536;
  localparam int WINDOW  = 1024;
  localparam int LATENCY = 2 + 64 + WINDOW;  // locked capture edge -> first meas_valid

  logic        dac_clk = 1'b0;
  logic        reset_n;
  logic        locked;
  logic        mon_toggle;
  logic        clear_err;
  logic        mv16, ok16, err16;
  logic [15:0] mc16;
  logic        mv8, ok8, err8;
  logic [7:0]  mc8;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  bit  rec [0:RECN-1];
  bit  script [$];
  int  period = 2;
  int  ph     = 0;
  bit  err_m  = 1'b0;
  bit  err8_m = 1'b0;

  clk_freq_monitor #(.CNT_W(16), .WINDOW(1024), .SETTLE(64), .EXP_EDGES(512), .TOL(2)) u_dut16 (
    .dac_clk(dac_clk), .reset_n(reset_n), .locked(locked), .mon_toggle(mon_toggle),
    .clear_err(clear_err), .meas_valid(mv16), .meas_count(mc16), .freq_ok(ok16), .freq_err(err16)
  );

  clk_freq_monitor #(.CNT_W(8), .WINDOW(1024), .SETTLE(64), .EXP_EDGES(250), .TOL(2)) u_dut8 (
    .dac_clk(dac_clk), .reset_n(reset_n), .locked(locked), .mon_toggle(mon_toggle),
    .clear_err(clear_err), .meas_valid(mv8), .meas_count(mc8), .freq_ok(ok8), .freq_err(err8)
  );

  always #5 dac_clk = ~dac_clk;

  // Record the toggle level seen at each rising edge.
  always @(posedge dac_clk) begin
    cyc <= cyc + 1;
    if (cyc + 1 < RECN) rec[cyc + 1] <= mon_toggle;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and drive mon_toggle for the next rising edge.
  task automatic tick();
    @(negedge dac_clk);
    if (script.size() > 0) begin
      if (script.pop_front()) mon_toggle = ~mon_toggle;
    end else if (period != 0) begin
      ph++;
      if (ph >= period) begin
        ph = 0;
        mon_toggle = ~mon_toggle;
      end
    end
  endtask

  function automatic bit in_tol(input int n, input int e);
    return ((n - e) <= 2) && ((e - n) <= 2);
  endfunction

  function automatic int model_count(input int v);
    int n = 0;
    for (int j = v - 1026; j <= v - 3; j++) if (rec[j] != rec[j + 1]) n++;
    return n;
  endfunction

  task automatic wait_valid(input int budget, output int v);
    int k = 0;
    v = -1;
    while (k < budget) begin
      tick();
      k++;
      if (mv16 === 1'b1) begin
        v = cyc;
        break;
      end
    end
    check("valid_seen", 32'(v >= 0), 1);
  endtask

  task automatic check_window(input int v, input string tag);
    int n, s8;
    bit ok, ok_8;
    if (v < 1026) return;
    n    = model_count(v);
    s8   = (n > 255) ? 255 : n;
    ok   = in_tol(n, 512);
    ok_8 = in_tol(s8, 250);
    err_m  = err_m | ~ok;
    err8_m = err8_m | ~ok_8;
    check({tag, "_cnt"},   32'(mc16), n);
    check({tag, "_ok"},    32'(ok16), 32'(ok));
    check({tag, "_err"},   32'(err16), 32'(err_m));
    check({tag, "_v8"},    32'(mv8), 1);
    check({tag, "_cnt8"},  32'(mc8), s8);
    check({tag, "_ok8"},   32'(ok8), 32'(ok_8));
    check({tag, "_err8"},  32'(err8), 32'(err8_m));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mv"},  32'(mv16), 0);
    check({tag, "_mc"},  32'(mc16), 0);
    check({tag, "_ok"},  32'(ok16), 0);
    check({tag, "_err"}, 32'(err16), 0);
    check({tag, "_mv8"}, 32'(mv8), 0);
    check({tag, "_mc8"}, 32'(mc8), 0);
    check({tag, "_er8"}, 32'(err8), 0);
  endtask

  // Script the next window (starting at the valid seen on cycle v) to hold
  // exactly 'target' transitions, with toggle positions shuffled.
  task automatic load_script(input int v, input int target);
    int t0, k, j;
    bit flags [1021];
    bit tmp;
    t0 = 0;
    if (rec[v - 2] != rec[v - 1]) t0++;
    if (rec[v - 1] != rec[v]) t0++;
    if (rec[v] != mon_toggle) t0++;
    k = target - t0;
    for (int i = 0; i < 1021; i++) flags[i] = (i < k);
    for (int i = 1020; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = flags[i]; flags[i] = flags[j]; flags[j] = tmp;
    end
    script.delete();
    for (int i = 0; i < 1021; i++) script.push_back(flags[i]);
    period = 0;
    ph = 0;
  endtask

  initial begin
    int v, vprev, n0, pulses;
    int targets [8];
    logic [15:0] mc_hold;

    reset_n = 1'b0; locked = 1'b0; mon_toggle = 1'b0; clear_err = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;

    // No lock: nothing is ever reported.
    pulses = 0;
    repeat (5000) begin
      tick();
      if (mv16 === 1'b1 || mv8 === 1'b1) pulses++;
    end
    check("nolock_pulses", pulses, 0);
    check("nolock_ok", 32'(ok16), 0);
    check("nolock_err", 32'(err16), 0);

    // Lock and measure a 2-cycle toggle.
    locked = 1'b1;
    n0 = cyc;
    wait_valid(2000, v);
    check("first_latency", v, n0 + 1 + LATENCY);
    check_window(v, "w0");
    for (int w = 0; w < 3; w++) begin
      vprev = v;
      wait_valid(1100, v);
      check("win_spacing", v - vprev, WINDOW);
      check_window(v, "steady");
      tick();
      check("pulse_width", 32'(mv16), 0);
    end

    // Slow toggle: out of tolerance, sticky error.
    period = 3; ph = 0;
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, v);
      check_window(v, "slow");
    end
    period = 2; ph = 0;
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, v);
      check_window(v, "restore");
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    err_m = 1'b0; err8_m = 1'b0;
    check("clear_err16", 32'(err16), 0);
    check("clear_err8", 32'(err8), 0);

    // Tolerance boundaries, then random counts around the target.
    wait_valid(1100, v);
    check_window(v, "pre_bound");
    targets[0] = 510; targets[1] = 514; targets[2] = 509; targets[3] = 515;
    for (int i = 4; i < 8; i++) targets[i] = int'($urandom_range(520, 504));
    for (int i = 0; i < 8; i++) begin
      load_script(v, targets[i]);
      wait_valid(1100, v);
      check_window(v, (i < 4) ? "bound" : "rand");
    end

    // Error and clear on the same cycle: error wins.
    load_script(v, 400);
    while (cyc < v + 1023) tick();
    clear_err = 1'b1;
    tick();
    v = cyc;
    clear_err = 1'b0;
    check("clrsame_valid", 32'(mv16), 1);
    err_m = 1'b0; err8_m = 1'b0;
    check_window(v, "clrsame");

    // Good window, then lock loss at win_cnt 500.
    period = 2; ph = 0;
    wait_valid(1100, v);
    check_window(v, "prelose");
    while (cyc < v + 500) tick();
    locked = 1'b0;
    mc_hold = mc16;
    repeat (3) tick();
    check("lose_ok", 32'(ok16), 0);
    pulses = 0;
    repeat (800) begin
      tick();
      if (mv16 === 1'b1 || mv8 === 1'b1) pulses++;
    end
    check("lose_pulses", pulses, 0);
    check("lose_hold_cnt", 32'(mc16), 32'(mc_hold));
    check("lose_err", 32'(err16), 32'(err_m));
    locked = 1'b1;
    n0 = cyc;
    wait_valid(2000, v);
    check("relock_latency", v, n0 + 1 + LATENCY);
    check_window(v, "relock");

    // Stuck toggle.
    period = 0;
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, v);
      check_window(v, "stuck");
    end

    // Asynchronous reset in the middle of a window.
    period = 2; ph = 0;
    repeat (300) tick();
    #2 reset_n = 1'b0;
    #1 check_zero("midreset");
    tick();
    reset_n = 1'b1;
    err_m = 1'b0; err8_m = 1'b0;
    n0 = cyc;
    wait_valid(2000, v);
    check("reset_latency", v, n0 + 1 + LATENCY);
    check_window(v, "postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
